noc_link_tx: RTL and testbench
==============================

Name: noc_link_tx

Overview:
- Credit-based link transmitter that feeds one router input port. It is the sending end of the per-VC buffer/credit protocol the router's input virtual channels implement.
- Accepts wormhole packets (sop/eop-delimited flits) from a local source or an upstream output stage.
- Allocates one output VC per packet and stamps VC, priority, packet ID and head/tail onto every flit.
- Sends a flit only when the receiver holds a free buffer slot; tracks slots with per-VC credit counters refilled by returned credits.

Parameters:
- DATA_WIDTH, 512, payload bits per flit
- VC_NUM, 4, virtual channels on the link (≥2)
- VC_DEPTH, 16, receiver buffer depth per VC; initial credit count
- PRIO_WIDTH, 2, QoS priority bits
- PKT_ID_WIDTH, 8, packet ID counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- src_valid  in  1  source flit valid
- src_ready  out  1  flit accepted when src_valid & src_ready
- src_data  in  DATA_WIDTH  payload
- src_sop  in  1  first flit of packet
- src_eop  in  1  last flit of packet
- src_prio  in  PRIO_WIDTH  priority; sampled on head flit only
- link_valid  out  1  flit on link this cycle
- link_data  out  DATA_WIDTH  payload
- link_vc  out  VC_NUM  one-hot VC of flit
- link_prio  out  PRIO_WIDTH  packet priority
- link_pkt_id  out  PKT_ID_WIDTH  packet ID
- link_head  out  1  head flit
- link_tail  out  1  tail flit
- credit_in  in  VC_NUM  one pulse per VC = one slot freed on that VC
- vc_credit_zero  out  VC_NUM  per-VC credit counter == 0
- proto_err  out  1  sticky error flag

Behaviour:
- Reset: state IDLE; all credit counters = VC_DEPTH; rr pointer = 0; pkt_id counter = 0; all link_* outputs = 0; proto_err = 0; vc_credit_zero = 0.
- Credit counter width is $clog2(VC_DEPTH+1).
- FSM states: IDLE and BODY.
- IDLE, head flit (src_sop = 1):
  - src_ready = 1 iff any VC credit > 0.
  - On accept, the round-robin picker grants the first VC with credit > 0 at or after the rr pointer.
  - cur_vc, cur_prio (from src_prio) and cur_id (pkt_id counter) are latched.
  - rr pointer moves to granted VC + 1 (mod VC_NUM).
  - If src_eop = 0, go to BODY; if src_sop & src_eop, emit a single head+tail flit and stay in IDLE.
- IDLE, non-head flit (src_valid & !src_sop): src_ready = 1; flit dropped, nothing sent; proto_err set.
- BODY:
  - src_ready = credit[cur_vc] > 0. Other VCs' credits are irrelevant (wormhole, VC held until tail).
  - Accepted flit sent on cur_vc with head = 0.
  - src_sop = 1 in BODY: flit treated as body; proto_err set.
  - On accepted eop: tail = 1, go to IDLE.
- pkt_id counter increments on every accepted tail flit; wraps 2^PKT_ID_WIDTH-1 → 0.
- Latency: a flit accepted at edge N appears on link_* in cycle N+1 (registered outputs).
- link_valid drops to 0 in any cycle with no accept; link_data and the other fields then hold their last values. There is no link-side backpressure.
- Credit update per VC each edge: count + credit_in[v] − sent[v].
  - Simultaneous send and return on the same VC: count unchanged.
  - A return while count == VC_DEPTH (and no send): saturate at VC_DEPTH, set proto_err.
- A credit returned in cycle M is visible in src_ready in cycle M+1. There is no combinational path from credit_in to src_ready.
- vc_credit_zero is registered and mirrors the counters.
- Reset asserted mid-packet: everything returns to reset values immediately; the partial packet is abandoned. The receiver is reset by the same rst_n.

Decomposition:
- noc_link_pkg holds:
  - link_flit_t packed struct {data, vc (one-hot), prio, pkt_id, head, tail}
  - tx_state_e {IDLE, BODY}
  - CRED_W localparam function
- Sub-module noc_vc_rr_pick: combinational round-robin picker; inputs eligible mask and pointer; outputs one-hot grant and any_grant.

Test Plan:
1. Reset: after rst_n release, link_valid = 0, vc_credit_zero = 4'b0000, proto_err = 0; src_ready = 1 when a head is offered.
2. Single flit, sop = eop = 1, prio = 2: next cycle link_valid = 1, head = tail = 1, link_vc = 4'b0001, pkt_id = 0, link_prio = 2; VC0 credit = 15; back in IDLE.
3. Round-robin: four back-to-back single-flit packets → link_vc = 0001, 0010, 0100, 1000; pkt_id = 0..3.
4. Credit exhaustion: 20-flit packet with no returns → 16 flits sent on VC0, src_ready = 0, vc_credit_zero[0] = 1. Pulse credit_in[0] 4 times → remaining 4 flits sent, last with tail = 1. Also drive send plus credit_in[0] in the same cycle → count unchanged.
5. Protocol errors: body flit in IDLE → dropped, no link_valid, proto_err = 1. Credit return on a full VC → count stays 16, proto_err = 1.
6. Reset mid-packet after 3 of 8 flits: outputs and credits return to reset values; next head uses VC0 with pkt_id = 0.

Source files
------------

// File: rtl/noc_link_pkg.sv
// Shared types for the credit-based NoC link transmitter: flit layout,
// transmitter FSM states and the credit counter width helper.
package noc_link_pkg;

  localparam int LINK_DATA_W = 512;
  localparam int LINK_VC_NUM = 4;
  localparam int LINK_PRIO_W = 2;
  localparam int LINK_ID_W   = 8;

  typedef struct packed {
    logic [LINK_DATA_W-1:0] data;
    logic [LINK_VC_NUM-1:0] vc;
    logic [LINK_PRIO_W-1:0] prio;
    logic [LINK_ID_W-1:0]   pkt_id;
    logic                   head;
    logic                   tail;
  } link_flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } tx_state_e;

  // A counter must hold every value 0..depth inclusive.
  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_vc_rr_pick.sv
// Combinational round-robin picker: grants the first eligible VC at or
// after the pointer, wrapping around.
module noc_vc_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any_grant
);

  int idx;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any_grant && eligible[idx]) begin
        grant[idx] = 1'b1;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_link_tx.sv
// Credit-based link transmitter: allocates one VC per wormhole packet,
// stamps flit metadata and sends only when the receiver has a free slot.
module noc_link_tx
  import noc_link_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int VC_NUM       = 4,
  parameter int VC_DEPTH     = 16,
  parameter int PRIO_WIDTH   = 2,
  parameter int PKT_ID_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [DATA_WIDTH-1:0]   src_data,
  input  logic                    src_sop,
  input  logic                    src_eop,
  input  logic [PRIO_WIDTH-1:0]   src_prio,
  output logic                    link_valid,
  output logic [DATA_WIDTH-1:0]   link_data,
  output logic [VC_NUM-1:0]       link_vc,
  output logic [PRIO_WIDTH-1:0]   link_prio,
  output logic [PKT_ID_WIDTH-1:0] link_pkt_id,
  output logic                    link_head,
  output logic                    link_tail,
  input  logic [VC_NUM-1:0]       credit_in,
  output logic [VC_NUM-1:0]       vc_credit_zero,
  output logic                    proto_err
);

  localparam int CRED_W = cred_w(VC_DEPTH);
  localparam int PTR_W  = $clog2(VC_NUM);
  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(VC_DEPTH);

  // Handshake: a source flit transfers on any edge where src_valid && src_ready;
  // src_ready depends only on registered state and src_sop, never on credit_in.

  tx_state_e                state_q, state_d;
  logic [CRED_W-1:0]        cred_q [VC_NUM];
  logic [CRED_W-1:0]        cred_d [VC_NUM];
  logic [PTR_W-1:0]         rr_q, rr_d, rr_next;
  logic [PKT_ID_WIDTH-1:0]  id_q, id_d, cur_id_q, cur_id_d;
  logic [VC_NUM-1:0]        cur_vc_q, cur_vc_d;
  logic [PRIO_WIDTH-1:0]    cur_prio_q, cur_prio_d;

  logic                     link_valid_q, link_valid_d;
  logic [DATA_WIDTH-1:0]    link_data_q, link_data_d;
  logic [VC_NUM-1:0]        link_vc_q, link_vc_d;
  logic [PRIO_WIDTH-1:0]    link_prio_q, link_prio_d;
  logic [PKT_ID_WIDTH-1:0]  link_pkt_id_q, link_pkt_id_d;
  logic                     link_head_q, link_head_d;
  logic                     link_tail_q, link_tail_d;
  logic                     proto_err_q, proto_err_d;
  logic [VC_NUM-1:0]        zero_q, zero_d;

  logic [VC_NUM-1:0]        has_cred, grant, sent;
  logic                     any_grant, accept, send;

  always_comb begin
    has_cred = '0;
    for (int v = 0; v < VC_NUM; v++) has_cred[v] = (cred_q[v] != '0);
  end

  noc_vc_rr_pick #(
    .N     (VC_NUM),
    .PTR_W (PTR_W)
  ) u_pick (
    .eligible  (has_cred),
    .ptr       (rr_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  always_comb begin
    rr_next = '0;
    for (int v = 0; v < VC_NUM; v++)
      if (grant[v]) rr_next = PTR_W'((v + 1) % VC_NUM);
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    id_d          = id_q;
    cur_id_d      = cur_id_q;
    cur_vc_d      = cur_vc_q;
    cur_prio_d    = cur_prio_q;
    link_valid_d  = 1'b0;
    link_data_d   = link_data_q;
    link_vc_d     = link_vc_q;
    link_prio_d   = link_prio_q;
    link_pkt_id_d = link_pkt_id_q;
    link_head_d   = link_head_q;
    link_tail_d   = link_tail_q;
    proto_err_d   = proto_err_q;
    send          = 1'b0;
    sent          = '0;

    // Stray non-head flits in IDLE are swallowed so the source never stalls.
    if (state_q == IDLE) src_ready = src_sop ? any_grant : 1'b1;
    else                 src_ready = |(has_cred & cur_vc_q);
    accept = src_valid && src_ready;

    if (accept) begin
      if (state_q == IDLE) begin
        if (src_sop) begin
          send          = 1'b1;
          link_vc_d     = grant;
          link_prio_d   = src_prio;
          link_pkt_id_d = id_q;
          link_head_d   = 1'b1;
          link_tail_d   = src_eop;
          rr_d          = rr_next;
          cur_vc_d      = grant;
          cur_prio_d    = src_prio;
          cur_id_d      = id_q;
          if (src_eop) id_d = id_q + PKT_ID_WIDTH'(1);
          else         state_d = BODY;
        end else begin
          proto_err_d = 1'b1;
        end
      end else begin
        send          = 1'b1;
        link_vc_d     = cur_vc_q;
        link_prio_d   = cur_prio_q;
        link_pkt_id_d = cur_id_q;
        link_head_d   = 1'b0;
        link_tail_d   = src_eop;
        if (src_sop) proto_err_d = 1'b1;
        if (src_eop) begin
          state_d = IDLE;
          id_d    = id_q + PKT_ID_WIDTH'(1);
        end
      end
    end

    if (send) begin
      link_valid_d = 1'b1;
      link_data_d  = src_data;
      sent         = link_vc_d;
    end

    // A return onto an already-full VC is a receiver bug: hold and flag it.
    zero_d = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      cred_d[v] = cred_q[v];
      if (credit_in[v] && !sent[v] && cred_q[v] == CRED_FULL)
        proto_err_d = 1'b1;
      else
        cred_d[v] = cred_q[v] + CRED_W'(credit_in[v]) - CRED_W'(sent[v]);
      zero_d[v] = (cred_d[v] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      for (int v = 0; v < VC_NUM; v++) cred_q[v] <= CRED_FULL;
      rr_q          <= '0;
      id_q          <= '0;
      cur_id_q      <= '0;
      cur_vc_q      <= '0;
      cur_prio_q    <= '0;
      link_valid_q  <= 1'b0;
      link_data_q   <= '0;
      link_vc_q     <= '0;
      link_prio_q   <= '0;
      link_pkt_id_q <= '0;
      link_head_q   <= 1'b0;
      link_tail_q   <= 1'b0;
      proto_err_q   <= 1'b0;
      zero_q        <= '0;
    end else begin
      state_q       <= state_d;
      for (int v = 0; v < VC_NUM; v++) cred_q[v] <= cred_d[v];
      rr_q          <= rr_d;
      id_q          <= id_d;
      cur_id_q      <= cur_id_d;
      cur_vc_q      <= cur_vc_d;
      cur_prio_q    <= cur_prio_d;
      link_valid_q  <= link_valid_d;
      link_data_q   <= link_data_d;
      link_vc_q     <= link_vc_d;
      link_prio_q   <= link_prio_d;
      link_pkt_id_q <= link_pkt_id_d;
      link_head_q   <= link_head_d;
      link_tail_q   <= link_tail_d;
      proto_err_q   <= proto_err_d;
      zero_q        <= zero_d;
    end
  end

  assign link_valid     = link_valid_q;
  assign link_data      = link_data_q;
  assign link_vc        = link_vc_q;
  assign link_prio      = link_prio_q;
  assign link_pkt_id    = link_pkt_id_q;
  assign link_head      = link_head_q;
  assign link_tail      = link_tail_q;
  assign proto_err      = proto_err_q;
  assign vc_credit_zero = zero_q;

endmodule

// File: tb/tb_noc_link_tx.sv
// Bench for noc_link_tx: directed scenarios then random traffic, all scored
// against a packet-level model of VC allocation and credit accounting.
module tb_noc_link_tx;
  import noc_link_pkg::*;

  localparam int DW = 512;
  localparam int VN = 4;
  localparam int VD = 16;
  localparam int PW = 2;
  localparam int IW = 8;
  localparam int FW = $bits(link_flit_t);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [DW-1:0] src_data = '0;
  logic          src_sop = 1'b0;
  logic          src_eop = 1'b0;
  logic [PW-1:0] src_prio = '0;
  logic          link_valid;
  logic [DW-1:0] link_data;
  logic [VN-1:0] link_vc;
  logic [PW-1:0] link_prio;
  logic [IW-1:0] link_pkt_id;
  logic          link_head;
  logic          link_tail;
  logic [VN-1:0] credit_in = '0;
  logic [VN-1:0] vc_credit_zero;
  logic          proto_err;
  logic [FW-1:0] dut_flit;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  noc_link_tx #(
    .DATA_WIDTH(DW), .VC_NUM(VN), .VC_DEPTH(VD), .PRIO_WIDTH(PW), .PKT_ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_sop(src_sop), .src_eop(src_eop), .src_prio(src_prio),
    .link_valid(link_valid), .link_data(link_data), .link_vc(link_vc),
    .link_prio(link_prio), .link_pkt_id(link_pkt_id),
    .link_head(link_head), .link_tail(link_tail),
    .credit_in(credit_in), .vc_credit_zero(vc_credit_zero), .proto_err(proto_err)
  );

  assign dut_flit = {link_data, link_vc, link_prio, link_pkt_id, link_head, link_tail};

  // ---------------- scoreboard / model state ----------------
  int            total = 0;
  int            bad = 0;
  logic [FW-1:0] exp_q[$];
  int            m_cred[VN];
  int            m_rr;
  bit            m_body;
  int            m_vc;
  int            m_prio;
  int            m_id;
  int            m_cur_id;
  bit            m_err;
  bit            m_send;
  logic [FW-1:0] m_last;

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk_flit(input logic [DW-1:0] d, input int vc, input int prio,
                                            input int id, input bit head, input bit tail);
    link_flit_t f;
    f.data   = d;
    f.vc     = '0;
    f.vc[vc] = 1'b1;
    f.prio   = PW'(prio);
    f.pkt_id = IW'(id);
    f.head   = head;
    f.tail   = tail;
    return f;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VN; v++) m_cred[v] = VD;
    m_rr = 0; m_body = 0; m_vc = 0; m_prio = 0; m_id = 0; m_cur_id = 0;
    m_err = 0; m_send = 0; m_last = '0;
    exp_q.delete();
  endtask

  function automatic logic [VN-1:0] m_zero();
    logic [VN-1:0] z;
    for (int v = 0; v < VN; v++) z[v] = (m_cred[v] == 0);
    return z;
  endfunction

  // ---------------- driver tasks ----------------
  // Entered #1 after a rising edge; applies reset asynchronously mid-cycle.
  task automatic do_reset();
    src_valid = 0; src_sop = 0; src_eop = 0; credit_in = '0;
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_link_valid", link_valid, 1'b0);
    chk("rst_fields", dut_flit, '0);
    chk("rst_credit_zero", vc_credit_zero, '0);
    chk("rst_proto_err", proto_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic cycle(input bit v, input bit sop, input bit eop, input int prio,
                       input logic [DW-1:0] d, input logic [VN-1:0] cred);
    bit exp_ready;
    bit acc;
    int sent_vc;
    src_valid = v; src_sop = sop; src_eop = eop; src_prio = PW'(prio);
    src_data = d; credit_in = cred;
    #1;
    if (!m_body) begin
      exp_ready = 1;
      if (sop) begin
        exp_ready = 0;
        for (int i = 0; i < VN; i++) if (m_cred[i] > 0) exp_ready = 1;
      end
    end else begin
      exp_ready = (m_cred[m_vc] > 0);
    end
    if (v) chk("src_ready", src_ready, exp_ready);
    acc = v && exp_ready;
    m_send = 0;
    sent_vc = -1;
    if (acc && !m_body && sop) begin
      for (int i = 0; i < VN; i++) begin
        if (sent_vc < 0 && m_cred[(m_rr + i) % VN] > 0) sent_vc = (m_rr + i) % VN;
      end
      m_rr = (sent_vc + 1) % VN;
      m_vc = sent_vc; m_prio = prio; m_cur_id = m_id;
      m_last = mk_flit(d, m_vc, m_prio, m_cur_id, 1, eop);
      if (eop) m_id = (m_id + 1) % (1 << IW);
      else     m_body = 1;
    end else if (acc && !m_body) begin
      m_err = 1;
    end else if (acc) begin
      sent_vc = m_vc;
      if (sop) m_err = 1;
      m_last = mk_flit(d, m_vc, m_prio, m_cur_id, 0, eop);
      if (eop) begin
        m_body = 0;
        m_id = (m_id + 1) % (1 << IW);
      end
    end
    if (sent_vc >= 0) begin
      m_send = 1;
      exp_q.push_back(m_last);
    end
    for (int i = 0; i < VN; i++) begin
      if (cred[i] && sent_vc != i && m_cred[i] == VD) m_err = 1;
      else m_cred[i] = m_cred[i] + int'(cred[i]) - ((sent_vc == i) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("link_valid", link_valid, m_send);
    if (link_valid) begin
      if (exp_q.size() > 0) chk("flit", dut_flit, exp_q.pop_front());
      else chk("extra_flit", link_valid, 1'b0);
    end
    chk("fields_hold", dut_flit, m_last);
    chk("proto_err", proto_err, m_err);
    chk("credit_zero", vc_credit_zero, m_zero());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk); #1;
    do_reset();

    // Single head+tail flit, priority 2.
    cycle(1, 1, 1, 2, rnd_data(), '0);
    cycle(0, 0, 0, 0, '0, '0);

    // Round-robin across four single-flit packets from a fresh reset.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, i, rnd_data(), '0);
    cycle(0, 0, 0, 0, '0, '0);

    // Credit exhaustion on VC0, then refill including send+return together.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, i == 0, 0, 1, rnd_data(), '0);
    repeat (2) cycle(1, 0, 0, 1, rnd_data(), '0);
    cycle(0, 0, 0, 0, '0, 4'b0001);
    for (int i = 16; i < 20; i++) cycle(1, 0, i == 19, 1, rnd_data(), (i < 19) ? 4'b0001 : 4'b0000);
    cycle(1, 1, 1, 3, rnd_data(), '0);

    // Protocol errors: body flit in IDLE, credit return on a full VC.
    do_reset();
    cycle(1, 0, 0, 0, rnd_data(), '0);
    cycle(0, 0, 0, 0, '0, '0);
    do_reset();
    cycle(0, 0, 0, 0, '0, 4'b0001);
    for (int i = 0; i < 17; i++) cycle(1, i == 0, i == 16, 0, rnd_data(), '0);

    // Reset in the middle of an 8-flit packet.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, i == 0, 0, 1, rnd_data(), '0);
    do_reset();
    cycle(1, 1, 1, 1, rnd_data(), '0);

    // Random traffic with random credit returns.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      bit v, sop, eop;
      logic [VN-1:0] cr;
      v   = ($urandom_range(0, 9) < 7);
      sop = m_body ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 29) != 0);
      eop = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < VN; i++)
        cr[i] = (m_cred[i] < VD) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
      cycle(v, sop, eop, $urandom_range(0, 3), rnd_data(), cr);
    end
    cycle(0, 0, 0, 0, '0, '0);
    chk("scoreboard_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
